adc_sample_fifo: RTL and testbench
==================================

Name: adc_sample_fifo

Overview:
- Upstream stage that feeds the cpu core's adcdata input.
- Captures ADC samples on a strobe and buffers them in a show-ahead FIFO.
- Presents samples to the cpu with a valid/ready handshake: the cpu drives input_ready and this block drives adc_valid.
- Tracks dropped samples when the FIFO is full and reports occupancy for software polling.

Parameters:
- DWIDTH, 32, width of adcdata presented to the cpu.
- ADCW, 12, raw ADC sample width; must be 1..DWIDTH.
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- SIGNED, 0, 1 = sign-extend samples to DWIDTH, 0 = zero-extend.
- AVGLOG2, 2, log2 of the averaging block length; used only with ADC_AVG_EN.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- adc_strobe  in  1  one-cycle pulse; adc_sample is valid this cycle.
- adc_sample  in  ADCW  raw converter sample.
- adcdata  out  DWIDTH  head-of-FIFO sample, extended to DWIDTH.
- adc_valid  out  1  adcdata holds a valid sample.
- input_ready  in  1  cpu accepts adcdata this cycle.
- clr_ovf  in  1  synchronous clear of overflow and drop_count.
- fill_count  out  $clog2(DEPTH)+1  current number of entries.
- overflow  out  1  sticky; set when a sample is dropped.
- drop_count  out  16  saturating count of dropped samples.

Behaviour:
- Reset (reset=0, asynchronous):
  - Read/write pointers = 0, fill_count = 0, adc_valid = 0, adcdata = 0.
  - overflow = 0, drop_count = 0.
  - Averaging accumulator and counter = 0.
  - Any sample in flight is discarded.
  - The first edge after deassertion operates normally.
- Push request: adc_strobe=1 (or an averaged result, see the optional feature).
- Pop: adc_valid && input_ready; the head advances on that edge.
- Show-ahead read path:
  - adcdata and adc_valid are registered from FIFO state.
  - A sample pushed into an empty FIFO at edge N appears with adc_valid=1 after edge N (latency 1 cycle).
  - adcdata is stable while adc_valid=1 && input_ready=0.
- Push, not full: write at wptr, wptr = (wptr+1) mod DEPTH, fill_count + 1.
- Push when full:
  - With a pop in the same cycle: the push is accepted and fill_count stays DEPTH.
  - Without a pop: the sample is dropped, overflow <= 1, drop_count increments and saturates at 16'hFFFF.
- Push and pop together, not empty and not full: fill_count unchanged.
- Pop when empty: impossible, because adc_valid=0. input_ready is ignored.
- Pointer wrap: pointers wrap modulo DEPTH. Full/empty are derived from fill_count (0 = empty, DEPTH = full).
- clr_ovf:
  - Clears overflow and drop_count on the next edge.
  - A drop in the same cycle takes priority: overflow=1, drop_count=1.
- Extension: adcdata = {(DWIDTH-ADCW) copies of sign or zero bit, sample}.

Optional Feature:
- Macro ADC_AVG_EN.
- When defined:
  - Samples from adc_strobe accumulate in an ADCW+AVGLOG2-bit accumulator with a block counter.
  - On the 2^AVGLOG2-th strobe, the block pushes accumulator>>AVGLOG2 (truncating mean) into the FIFO and clears the accumulator and counter.
  - Only averaged results are subject to full/drop rules.
  - Averaging is unsigned when SIGNED=0 and arithmetic when SIGNED=1.
- When undefined: every strobe pushes its sample directly and no accumulator logic exists.

Test Plan:
- Reset, then strobe 12'h001 once with input_ready=0 -> one cycle later adc_valid=1, adcdata=32'h00000001, fill_count=1; the value holds for 5 cycles.
- Strobe 12'h005..12'h00C (8 samples) with input_ready=0, then a 9th sample 12'h0FF -> fill_count=8, overflow=1, drop_count=1. Raising input_ready then yields 5..12 in order with no 0x0FF.
- FIFO full, strobe 12'h0AA in the same cycle as a pop -> no drop, fill_count stays 8, 0x0AA is read last.
- SIGNED=1, sample 12'h800 -> adcdata=32'hFFFFF800. SIGNED=0, same sample -> 32'h00000800.
- Pulse reset low mid-stream with fill_count=5 -> adc_valid=0, fill_count=0, overflow=0 immediately. The next strobe of 12'h123 appears after 1 cycle.
- ADC_AVG_EN, AVGLOG2=2, samples 10,11,12,13 -> exactly one push, adcdata=11. Samples 1,1,1,2 -> adcdata=1.

Source files
------------

// File: rtl/adc_sample_fifo.sv
// adc_sample_fifo: captures strobed ADC samples into a show-ahead FIFO and
// presents them to the cpu over a valid/ready handshake. Samples that arrive
// while the FIFO is full are dropped and counted.
// Optional block averaging is enabled by defining the macro ADC_AVG_EN.
module adc_sample_fifo #(
   parameter int DWIDTH  = 32,
   parameter int ADCW    = 12,
   parameter int DEPTH   = 8,
   parameter int SIGNED  = 0,
   parameter int AVGLOG2 = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     adc_strobe,
   input  logic [ADCW-1:0]          adc_sample,
   output logic [DWIDTH-1:0]        adcdata,
   output logic                     adc_valid,
   input  logic                     input_ready,
   input  logic                     clr_ovf,
   output logic [$clog2(DEPTH):0]   fill_count,
   output logic                     overflow,
   output logic [15:0]              drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int FW = AW + 1;

   // Reject parameter sets the pointer and extension logic cannot support.
   if (ADCW < 1 || ADCW > DWIDTH || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AVGLOG2 < 0) begin : g_bad_params
      $error("adc_sample_fifo: illegal parameter combination");
   end

   // Widen a raw sample to the cpu data width with sign or zero fill.
   function automatic logic [DWIDTH-1:0] extend(input logic [ADCW-1:0] s);
      logic [DWIDTH-1:0] r;
      r = DWIDTH'(s);
      for (int i = ADCW; i < DWIDTH; i++) begin
         r[i] = (SIGNED != 0) ? s[ADCW-1] : 1'b0;
      end
      return r;
   endfunction

   logic [ADCW-1:0] mem_r [DEPTH];
   logic [AW-1:0]   wptr_r, rptr_r, rptr_next_s;
   logic [FW-1:0]   fill_next_s, remain_s;
   logic [ADCW-1:0] head_s;
   logic            push_req_s, pop_s, full_s, accept_s, drop_s;
   logic [ADCW-1:0] push_data_s;

`ifdef ADC_AVG_EN
   localparam int ACCW = ADCW + AVGLOG2;
   localparam int CW   = (AVGLOG2 > 0) ? AVGLOG2 : 1;

   logic [ACCW-1:0] acc_r, sum_s, samp_ext_s, shifted_s;
   logic [CW-1:0]   cnt_r;
   logic            last_s;

   // Accumulate the block and form the truncating mean on its last strobe.
   always_comb begin
      samp_ext_s = ACCW'(adc_sample);
      for (int i = ADCW; i < ACCW; i++) begin
         samp_ext_s[i] = (SIGNED != 0) ? adc_sample[ADCW-1] : 1'b0;
      end
      sum_s  = acc_r + samp_ext_s;
      last_s = (cnt_r == CW'((1 << AVGLOG2) - 1));
      if (SIGNED != 0) begin
         shifted_s = ACCW'($signed(sum_s) >>> AVGLOG2);
      end else begin
         shifted_s = sum_s >> AVGLOG2;
      end
   end

   assign push_req_s  = adc_strobe & last_s;
   assign push_data_s = shifted_s[ADCW-1:0];

   // Averaging accumulator and block counter; cleared after each result.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         acc_r <= '0;
         cnt_r <= '0;
      end else if (adc_strobe) begin
         if (last_s) begin
            acc_r <= '0;
            cnt_r <= '0;
         end else begin
            acc_r <= sum_s;
            cnt_r <= cnt_r + CW'(1);
         end
      end else begin
         acc_r <= acc_r;
         cnt_r <= cnt_r;
      end
   end
`else
   assign push_req_s  = adc_strobe;
   assign push_data_s = adc_sample;
`endif

   // Handshake decode, occupancy update and the next head-of-FIFO value.
   always_comb begin
      pop_s       = adc_valid & input_ready;
      full_s      = (fill_count == FW'(DEPTH));
      accept_s    = push_req_s & (~full_s | pop_s);
      drop_s      = push_req_s & full_s & ~pop_s;
      fill_next_s = fill_count;
      case ({accept_s, pop_s})
         2'b10:   fill_next_s = fill_count + FW'(1);
         2'b01:   fill_next_s = fill_count - FW'(1);
         default: fill_next_s = fill_count;
      endcase
      if (pop_s) begin
         rptr_next_s = rptr_r + AW'(1);
         remain_s    = fill_count - FW'(1);
      end else begin
         rptr_next_s = rptr_r;
         remain_s    = fill_count;
      end
      // An empty FIFO forwards the incoming sample so latency stays one cycle.
      if (remain_s == FW'(0)) begin
         head_s = push_data_s;
      end else begin
         head_s = mem_r[rptr_next_s];
      end
   end

   // Sample storage; contents are only meaningful between the pointers.
   always_ff @(posedge clock) begin
      if (accept_s) begin
         mem_r[wptr_r] <= push_data_s;
      end
   end

   // Pointers, occupancy and the registered show-ahead output.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_r     <= '0;
         rptr_r     <= '0;
         fill_count <= '0;
         adc_valid  <= 1'b0;
         adcdata    <= '0;
      end else begin
         if (accept_s) begin
            wptr_r <= wptr_r + AW'(1);
         end else begin
            wptr_r <= wptr_r;
         end
         rptr_r     <= rptr_next_s;
         fill_count <= fill_next_s;
         adc_valid  <= (fill_next_s != FW'(0));
         if (fill_next_s != FW'(0)) begin
            adcdata <= extend(head_s);
         end else begin
            adcdata <= adcdata;
         end
      end
   end

   // Sticky overflow flag and saturating drop counter; a drop beats clr_ovf.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overflow   <= 1'b0;
         drop_count <= 16'h0000;
      end else if (drop_s) begin
         overflow <= 1'b1;
         if (clr_ovf) begin
            drop_count <= 16'h0001;
         end else if (drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'h0001;
         end else begin
            drop_count <= drop_count;
         end
      end else if (clr_ovf) begin
         overflow   <= 1'b0;
         drop_count <= 16'h0000;
      end else begin
         overflow   <= overflow;
         drop_count <= drop_count;
      end
   end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Directed testbench for adc_sample_fifo: one task per scenario, inline checks.
module tb_adc_sample_fifo;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        adc_strobe = 1'b0;
   logic [11:0] adc_sample = 12'h000;
   logic [31:0] adcdata;
   logic        adc_valid;
   logic        input_ready = 1'b0;
   logic        clr_ovf = 1'b0;
   logic [3:0]  fill_count;
   logic        overflow;
   logic [15:0] drop_count;

   logic        s_strobe = 1'b0;
   logic [11:0] s_sample = 12'h000;
   logic [31:0] s_adcdata;
   logic        s_valid;
   logic        s_ready = 1'b0;
   logic [3:0]  s_fill;
   logic        s_ovf;
   logic [15:0] s_drop;

   int vec_cnt = 0;
   int err_cnt = 0;

   always #5 clock = ~clock;

   adc_sample_fifo #(.DWIDTH(32), .ADCW(12), .DEPTH(8), .SIGNED(0), .AVGLOG2(2)) u_dut (
      .clock(clock), .reset(reset), .adc_strobe(adc_strobe), .adc_sample(adc_sample),
      .adcdata(adcdata), .adc_valid(adc_valid), .input_ready(input_ready), .clr_ovf(clr_ovf),
      .fill_count(fill_count), .overflow(overflow), .drop_count(drop_count));

   adc_sample_fifo #(.DWIDTH(32), .ADCW(12), .DEPTH(8), .SIGNED(1), .AVGLOG2(2)) u_dut_s (
      .clock(clock), .reset(reset), .adc_strobe(s_strobe), .adc_sample(s_sample),
      .adcdata(s_adcdata), .adc_valid(s_valid), .input_ready(s_ready), .clr_ovf(1'b0),
      .fill_count(s_fill), .overflow(s_ovf), .drop_count(s_drop));

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      vec_cnt++; if (adc_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_valid got %0b exp 0", adc_valid); end
      vec_cnt++; if (fill_count !== 4'd0) begin err_cnt++; $display("FAIL rst_fill got %0d exp 0", fill_count); end
      vec_cnt++; if (adcdata !== 32'h0) begin err_cnt++; $display("FAIL rst_data got %h exp 0", adcdata); end
      vec_cnt++; if (overflow !== 1'b0 || drop_count !== 16'h0) begin err_cnt++; $display("FAIL rst_ovf got %0b/%0d exp 0/0", overflow, drop_count); end
   endtask

   task automatic test_single_sample();
      adc_sample = 12'h001; adc_strobe = 1'b1;
      tick();
      adc_strobe = 1'b0;
      vec_cnt++; if (adc_valid !== 1'b1) begin err_cnt++; $display("FAIL single_valid got %0b exp 1", adc_valid); end
      vec_cnt++; if (adcdata !== 32'h00000001) begin err_cnt++; $display("FAIL single_data got %h exp 00000001", adcdata); end
      vec_cnt++; if (fill_count !== 4'd1) begin err_cnt++; $display("FAIL single_fill got %0d exp 1", fill_count); end
      for (int i = 0; i < 5; i++) begin
         tick();
         vec_cnt++; if (adcdata !== 32'h00000001 || adc_valid !== 1'b1) begin err_cnt++; $display("FAIL single_hold%0d got %h/%0b exp 00000001/1", i, adcdata, adc_valid); end
      end
      input_ready = 1'b1;
      tick();
      vec_cnt++; if (adc_valid !== 1'b0 || fill_count !== 4'd0) begin err_cnt++; $display("FAIL single_drain got %0b/%0d exp 0/0", adc_valid, fill_count); end
      // input_ready on an empty FIFO must not move anything
      tick();
      input_ready = 1'b0;
      vec_cnt++; if (adc_valid !== 1'b0 || fill_count !== 4'd0) begin err_cnt++; $display("FAIL empty_pop got %0b/%0d exp 0/0", adc_valid, fill_count); end
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 8; i++) begin
         adc_sample = 12'(5 + i); adc_strobe = 1'b1;
         tick();
      end
      adc_sample = 12'h0FF;
      tick();
      adc_strobe = 1'b0;
      vec_cnt++; if (fill_count !== 4'd8) begin err_cnt++; $display("FAIL ovf_fill got %0d exp 8", fill_count); end
      vec_cnt++; if (overflow !== 1'b1) begin err_cnt++; $display("FAIL ovf_flag got %0b exp 1", overflow); end
      vec_cnt++; if (drop_count !== 16'd1) begin err_cnt++; $display("FAIL ovf_drop got %0d exp 1", drop_count); end
      input_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         vec_cnt++; if (adc_valid !== 1'b1 || adcdata !== 32'(5 + i)) begin err_cnt++; $display("FAIL ovf_read%0d got %h/%0b exp %h/1", i, adcdata, adc_valid, 32'(5 + i)); end
         tick();
      end
      input_ready = 1'b0;
      vec_cnt++; if (adc_valid !== 1'b0 || fill_count !== 4'd0) begin err_cnt++; $display("FAIL ovf_empty got %0b/%0d exp 0/0", adc_valid, fill_count); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      vec_cnt++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin err_cnt++; $display("FAIL ovf_clr got %0b/%0d exp 0/0", overflow, drop_count); end
   endtask

   task automatic test_full_push_pop();
      for (int i = 0; i < 8; i++) begin
         adc_sample = 12'(32'h20 + i); adc_strobe = 1'b1;
         tick();
      end
      adc_sample = 12'h066;
      tick();
      vec_cnt++; if (drop_count !== 16'd1) begin err_cnt++; $display("FAIL prio_pre got %0d exp 1", drop_count); end
      adc_sample = 12'h055; clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0; adc_strobe = 1'b0;
      vec_cnt++; if (overflow !== 1'b1 || drop_count !== 16'd1) begin err_cnt++; $display("FAIL prio_drop got %0b/%0d exp 1/1", overflow, drop_count); end
      clr_ovf = 1'b1;
      tick();
      clr_ovf = 1'b0;
      adc_sample = 12'h0AA; adc_strobe = 1'b1; input_ready = 1'b1;
      tick();
      adc_strobe = 1'b0;
      vec_cnt++; if (fill_count !== 4'd8) begin err_cnt++; $display("FAIL pp_fill got %0d exp 8", fill_count); end
      vec_cnt++; if (overflow !== 1'b0 || drop_count !== 16'd0) begin err_cnt++; $display("FAIL pp_nodrop got %0b/%0d exp 0/0", overflow, drop_count); end
      for (int i = 1; i < 8; i++) begin
         vec_cnt++; if (adcdata !== 32'(32'h20 + i)) begin err_cnt++; $display("FAIL pp_read%0d got %h exp %h", i, adcdata, 32'(32'h20 + i)); end
         tick();
      end
      vec_cnt++; if (adc_valid !== 1'b1 || adcdata !== 32'h000000AA) begin err_cnt++; $display("FAIL pp_last got %h/%0b exp 000000AA/1", adcdata, adc_valid); end
      tick();
      input_ready = 1'b0;
      vec_cnt++; if (adc_valid !== 1'b0) begin err_cnt++; $display("FAIL pp_empty got %0b exp 0", adc_valid); end
   endtask

   task automatic test_sign_ext();
      adc_sample = 12'h800; adc_strobe = 1'b1;
      s_sample = 12'h800; s_strobe = 1'b1;
      tick();
      adc_strobe = 1'b0; s_strobe = 1'b0;
      vec_cnt++; if (s_adcdata !== 32'hFFFFF800 || s_valid !== 1'b1) begin err_cnt++; $display("FAIL sext got %h/%0b exp FFFFF800/1", s_adcdata, s_valid); end
      vec_cnt++; if (adcdata !== 32'h00000800) begin err_cnt++; $display("FAIL zext got %h exp 00000800", adcdata); end
      input_ready = 1'b1; s_ready = 1'b1;
      tick();
      input_ready = 1'b0; s_ready = 1'b0;
      vec_cnt++; if (adc_valid !== 1'b0 || s_valid !== 1'b0) begin err_cnt++; $display("FAIL ext_drain got %0b/%0b exp 0/0", adc_valid, s_valid); end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 8; i++) begin
         adc_sample = 12'(32'h30 + i); adc_strobe = 1'b1;
         tick();
      end
      adc_sample = 12'h077;
      tick();
      adc_strobe = 1'b0; input_ready = 1'b1;
      repeat (3) tick();
      input_ready = 1'b0;
      vec_cnt++; if (fill_count !== 4'd5 || overflow !== 1'b1) begin err_cnt++; $display("FAIL ar_pre got %0d/%0b exp 5/1", fill_count, overflow); end
      #2 reset = 1'b0;
      #1;
      vec_cnt++; if (adc_valid !== 1'b0 || fill_count !== 4'd0 || overflow !== 1'b0) begin err_cnt++; $display("FAIL ar_clear got %0b/%0d/%0b exp 0/0/0", adc_valid, fill_count, overflow); end
      vec_cnt++; if (adcdata !== 32'h0 || drop_count !== 16'd0) begin err_cnt++; $display("FAIL ar_data got %h/%0d exp 0/0", adcdata, drop_count); end
      reset = 1'b1;
      adc_sample = 12'h123; adc_strobe = 1'b1;
      tick();
      adc_strobe = 1'b0;
      vec_cnt++; if (adc_valid !== 1'b1 || adcdata !== 32'h00000123 || fill_count !== 4'd1) begin err_cnt++; $display("FAIL ar_after got %h/%0b/%0d exp 00000123/1/1", adcdata, adc_valid, fill_count); end
   endtask

   task automatic test_average();
      logic [11:0] blk_a [4];
      logic [11:0] blk_b [4];
      blk_a[0] = 12'd10; blk_a[1] = 12'd11; blk_a[2] = 12'd12; blk_a[3] = 12'd13;
      blk_b[0] = 12'd1;  blk_b[1] = 12'd1;  blk_b[2] = 12'd1;  blk_b[3] = 12'd2;
      for (int i = 0; i < 4; i++) begin
         adc_sample = blk_a[i]; adc_strobe = 1'b1;
         tick();
         adc_strobe = 1'b0;
         if (i < 3) begin
            vec_cnt++; if (adc_valid !== 1'b0) begin err_cnt++; $display("FAIL avg_a_early%0d got %0b exp 0", i, adc_valid); end
         end
      end
      vec_cnt++; if (adc_valid !== 1'b1 || adcdata !== 32'd11 || fill_count !== 4'd1) begin err_cnt++; $display("FAIL avg_a got %0d/%0b/%0d exp 11/1/1", adcdata, adc_valid, fill_count); end
      input_ready = 1'b1;
      tick();
      input_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         adc_sample = blk_b[i]; adc_strobe = 1'b1;
         tick();
         adc_strobe = 1'b0;
      end
      vec_cnt++; if (adc_valid !== 1'b1 || adcdata !== 32'd1 || fill_count !== 4'd1) begin err_cnt++; $display("FAIL avg_b got %0d/%0b/%0d exp 1/1/1", adcdata, adc_valid, fill_count); end
   endtask

   initial begin
      #12;
      test_reset();
      reset = 1'b1;
`ifdef ADC_AVG_EN
      test_average();
`else
      test_single_sample();
      test_overflow();
      test_full_push_pop();
      test_sign_ext();
      test_async_reset();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
